// File: rtl/pc_redirect_if.sv
// Front-end control bundle between the EX stage and the PC redirect unit.
// The EX stage (master) drives the redirect requests; the unit (slave) drives the fetch PC and flush controls.
interface pc_redirect_if;
    logic        stall_i;
    logic        branch_i;
    logic        br_sig_i;
    logic        jal_i;
    logic        jalr_i;
    logic        halt_i;
    logic [31:0] ex_pc_i;
    logic [31:0] imm_i;
    logic [31:0] rs1_i;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic        redirect_o;
    logic        flush_o;
    logic        misalign_o;
    logic        halted_o;

    modport master (
        output stall_i, branch_i, br_sig_i, jal_i, jalr_i, halt_i,
        output ex_pc_i, imm_i, rs1_i,
        input  pc_o, pc_plus4_o, redirect_o, flush_o, misalign_o, halted_o
    );

    modport slave (
        input  stall_i, branch_i, br_sig_i, jal_i, jalr_i, halt_i,
        input  ex_pc_i, imm_i, rs1_i,
        output pc_o, pc_plus4_o, redirect_o, flush_o, misalign_o, halted_o
    );
endinterface

// File: rtl/pc_redirect_unit.sv
// Program-counter owner: next-PC selection, redirect flush sequencing and halt freeze.
// A redirect raises flush_o for FLUSH_CYCLES consecutive cycles starting in the accept cycle.
module pc_redirect_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rst,
    pc_redirect_if.slave  bus
);
    typedef enum logic [1:0] {RUN, FLUSH, HALT} state_t;

    state_t      state, state_nxt;
    logic [2:0]  cnt, cnt_nxt;
    logic [31:0] pc_q, pc_nxt;
    logic        misalign_q, misalign_nxt;
    logic        halted_q;
    logic        take;
    logic        redirect;
    logic        flush;
    logic [31:0] pc_plus4;
    logic [31:0] target;

    assign pc_plus4 = pc_q + 32'd4;
    assign take     = (bus.branch_i & bus.br_sig_i) | bus.jal_i | bus.jalr_i;
    // JALR wins when several redirect sources are (illegally) raised together.
    assign target   = bus.jalr_i ? ((bus.rs1_i + bus.imm_i) & ~32'd1)
                                 : (bus.ex_pc_i + bus.imm_i);

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        pc_nxt       = pc_q;
        misalign_nxt = 1'b0;
        redirect     = 1'b0;
        flush        = 1'b0;
        case (state)
            RUN: begin
                if (bus.halt_i) begin
                    state_nxt = HALT;
                end else if (take) begin
                    // Redirect beats stall: the stalled younger work is wrong-path anyway.
                    redirect     = 1'b1;
                    flush        = 1'b1;
                    pc_nxt       = target;
                    misalign_nxt = target[1] & ~bus.jalr_i;
                    if (FLUSH_CYCLES > 1) begin
                        state_nxt = FLUSH;
                        cnt_nxt   = 3'(FLUSH_CYCLES - 1);
                    end
                end else if (!bus.stall_i) begin
                    pc_nxt = pc_plus4;
                end
            end
            FLUSH: begin
                flush   = 1'b1;
                cnt_nxt = cnt - 3'd1;
                if (cnt == 3'd1) begin
                    state_nxt = RUN;
                end
                if (!bus.stall_i) begin
                    pc_nxt = pc_plus4;
                end
            end
            HALT: begin
                state_nxt = HALT;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            cnt        <= 3'd0;
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            pc_q       <= pc_nxt;
            misalign_q <= misalign_nxt;
            halted_q   <= (state_nxt == HALT);
        end
    end

    assign bus.pc_o       = pc_q;
    assign bus.pc_plus4_o = pc_plus4;
    assign bus.redirect_o = redirect;
    assign bus.flush_o    = flush;
    assign bus.misalign_o = misalign_q;
    assign bus.halted_o   = halted_q;
endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed bench for pc_redirect_unit: one DUT with FLUSH_CYCLES=2, one with FLUSH_CYCLES=1.
// Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
module tb_pc_redirect_unit;
    logic clk;
    logic rst;
    int   tests;
    int   fails;

    pc_redirect_if ifa ();
    pc_redirect_if ifb ();

    pc_redirect_unit #(.RESET_PC(32'h0), .FLUSH_CYCLES(2)) dut2 (.clk(clk), .rst(rst), .bus(ifa));
    pc_redirect_unit #(.RESET_PC(32'h0), .FLUSH_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(ifb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ifa.stall_i = 0; ifa.branch_i = 0; ifa.br_sig_i = 0; ifa.jal_i = 0;
        ifa.jalr_i = 0; ifa.halt_i = 0; ifa.ex_pc_i = 0; ifa.imm_i = 0; ifa.rs1_i = 0;
        ifb.stall_i = 0; ifb.branch_i = 0; ifb.br_sig_i = 0; ifb.jal_i = 0;
        ifb.jalr_i = 0; ifb.halt_i = 0; ifb.ex_pc_i = 0; ifb.imm_i = 0; ifb.rs1_i = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (ifa.redirect_o !== 1'b0) begin fails++; $display("FAIL reset_redirect got %b exp 0", ifa.redirect_o); end
        tests++; if (ifa.misalign_o !== 1'b0) begin fails++; $display("FAIL reset_misalign got %b exp 0", ifa.misalign_o); end
        for (int i = 0; i < 4; i++) begin
            tests++; if (ifa.pc_o !== 32'(4 * i)) begin fails++; $display("FAIL free_pc[%0d] got %h exp %h", i, ifa.pc_o, 32'(4 * i)); end
            tests++; if (ifa.pc_plus4_o !== 32'(4 * i + 4)) begin fails++; $display("FAIL free_pc4[%0d] got %h exp %h", i, ifa.pc_plus4_o, 32'(4 * i + 4)); end
            tests++; if (ifa.flush_o !== 1'b0) begin fails++; $display("FAIL free_flush[%0d] got %b exp 0", i, ifa.flush_o); end
            tests++; if (ifa.halted_o !== 1'b0) begin fails++; $display("FAIL free_halted[%0d] got %b exp 0", i, ifa.halted_o); end
            tick();
        end
    endtask

    task automatic test_branch();
        // pc_o is 0x10 on entry
        ifa.branch_i = 1; ifa.br_sig_i = 1; ifa.ex_pc_i = 32'h40; ifa.imm_i = 32'hFFFF_FFF0;
        #1;
        tests++; if (ifa.redirect_o !== 1'b1) begin fails++; $display("FAIL br_redirect got %b exp 1", ifa.redirect_o); end
        tests++; if (ifa.flush_o !== 1'b1) begin fails++; $display("FAIL br_flush0 got %b exp 1", ifa.flush_o); end
        tick(); idle(); #1;
        tests++; if (ifa.pc_o !== 32'h30) begin fails++; $display("FAIL br_target got %h exp 00000030", ifa.pc_o); end
        tests++; if (ifa.flush_o !== 1'b1) begin fails++; $display("FAIL br_flush1 got %b exp 1", ifa.flush_o); end
        tests++; if (ifa.redirect_o !== 1'b0) begin fails++; $display("FAIL br_redirect1 got %b exp 0", ifa.redirect_o); end
        tick();
        tests++; if (ifa.pc_o !== 32'h34) begin fails++; $display("FAIL br_after got %h exp 00000034", ifa.pc_o); end
        tests++; if (ifa.flush_o !== 1'b0) begin fails++; $display("FAIL br_flush2 got %b exp 0", ifa.flush_o); end
        ifa.branch_i = 1; ifa.br_sig_i = 0; ifa.ex_pc_i = 32'h40; ifa.imm_i = 32'hFFFF_FFF0;
        #1;
        tests++; if (ifa.redirect_o !== 1'b0) begin fails++; $display("FAIL nt_redirect got %b exp 0", ifa.redirect_o); end
        tick(); idle(); #1;
        tests++; if (ifa.pc_o !== 32'h38) begin fails++; $display("FAIL nt_pc got %h exp 00000038", ifa.pc_o); end
    endtask

    task automatic test_jalr_stall();
        ifa.stall_i = 1; ifa.jalr_i = 1; ifa.rs1_i = 32'h1001; ifa.imm_i = 32'h4;
        #1;
        tests++; if (ifa.redirect_o !== 1'b1) begin fails++; $display("FAIL jalr_redirect got %b exp 1", ifa.redirect_o); end
        tick(); idle(); #1;
        tests++; if (ifa.pc_o !== 32'h1004) begin fails++; $display("FAIL jalr_target got %h exp 00001004", ifa.pc_o); end
        tests++; if (ifa.misalign_o !== 1'b0) begin fails++; $display("FAIL jalr_misalign got %b exp 0", ifa.misalign_o); end
        tick();
        tests++; if (ifa.pc_o !== 32'h1008) begin fails++; $display("FAIL jalr_after got %h exp 00001008", ifa.pc_o); end
    endtask

    task automatic test_jal_misalign();
        ifa.jal_i = 1; ifa.ex_pc_i = 32'h100; ifa.imm_i = 32'h2;
        #1;
        tests++; if (ifa.redirect_o !== 1'b1) begin fails++; $display("FAIL jal_redirect got %b exp 1", ifa.redirect_o); end
        tick();
        // second jump presented while flushing must be ignored
        ifa.jal_i = 1; ifa.ex_pc_i = 32'h200; ifa.imm_i = 32'h0;
        #1;
        tests++; if (ifa.pc_o !== 32'h102) begin fails++; $display("FAIL jal_target got %h exp 00000102", ifa.pc_o); end
        tests++; if (ifa.misalign_o !== 1'b1) begin fails++; $display("FAIL jal_misalign got %b exp 1", ifa.misalign_o); end
        tests++; if (ifa.redirect_o !== 1'b0) begin fails++; $display("FAIL jal_ignored got %b exp 0", ifa.redirect_o); end
        tick(); idle(); #1;
        tests++; if (ifa.pc_o !== 32'h106) begin fails++; $display("FAIL jal_after got %h exp 00000106", ifa.pc_o); end
        tests++; if (ifa.misalign_o !== 1'b0) begin fails++; $display("FAIL jal_misalign_end got %b exp 0", ifa.misalign_o); end
        tests++; if (ifa.flush_o !== 1'b0) begin fails++; $display("FAIL jal_flush_end got %b exp 0", ifa.flush_o); end
    endtask

    task automatic test_flush_stall();
        ifa.jal_i = 1; ifa.ex_pc_i = 32'h300; ifa.imm_i = 32'h0;
        tick(); idle();
        ifa.stall_i = 1;
        #1;
        tests++; if (ifa.flush_o !== 1'b1) begin fails++; $display("FAIL fs_flush1 got %b exp 1", ifa.flush_o); end
        tick();
        tests++; if (ifa.pc_o !== 32'h300) begin fails++; $display("FAIL fs_hold got %h exp 00000300", ifa.pc_o); end
        tests++; if (ifa.flush_o !== 1'b0) begin fails++; $display("FAIL fs_flush2 got %b exp 0", ifa.flush_o); end
        ifa.stall_i = 0;
        tick();
        tests++; if (ifa.pc_o !== 32'h304) begin fails++; $display("FAIL fs_resume got %h exp 00000304", ifa.pc_o); end
    endtask

    task automatic test_halt();
        do_reset();
        for (int i = 0; i < 8; i++) tick();
        tests++; if (ifa.pc_o !== 32'h20) begin fails++; $display("FAIL halt_pre_pc got %h exp 00000020", ifa.pc_o); end
        ifa.halt_i = 1; ifa.jal_i = 1; ifa.ex_pc_i = 32'h100; ifa.imm_i = 32'h0;
        #1;
        tests++; if (ifa.redirect_o !== 1'b0) begin fails++; $display("FAIL halt_redirect got %b exp 0", ifa.redirect_o); end
        tests++; if (ifa.flush_o !== 1'b0) begin fails++; $display("FAIL halt_flush got %b exp 0", ifa.flush_o); end
        tick(); idle();
        ifa.jal_i = 1; ifa.ex_pc_i = 32'h500;
        #1;
        for (int i = 0; i < 10; i++) begin
            tests++; if (ifa.pc_o !== 32'h20) begin fails++; $display("FAIL halt_pc[%0d] got %h exp 00000020", i, ifa.pc_o); end
            tests++; if (ifa.halted_o !== 1'b1) begin fails++; $display("FAIL halt_flag[%0d] got %b exp 1", i, ifa.halted_o); end
            tests++; if (ifa.flush_o !== 1'b0) begin fails++; $display("FAIL halt_flushq[%0d] got %b exp 0", i, ifa.flush_o); end
            tick();
        end
        do_reset();
        tests++; if (ifa.pc_o !== 32'h0) begin fails++; $display("FAIL halt_rst_pc got %h exp 00000000", ifa.pc_o); end
        tests++; if (ifa.halted_o !== 1'b0) begin fails++; $display("FAIL halt_rst_flag got %b exp 0", ifa.halted_o); end
    endtask

    task automatic test_reset_mid_flush();
        ifa.jal_i = 1; ifa.ex_pc_i = 32'h700; ifa.imm_i = 32'h0;
        tick(); idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        tests++; if (ifa.pc_o !== 32'h0) begin fails++; $display("FAIL rmf_pc got %h exp 00000000", ifa.pc_o); end
        tests++; if (ifa.flush_o !== 1'b0) begin fails++; $display("FAIL rmf_flush got %b exp 0", ifa.flush_o); end
        tick();
        tests++; if (ifa.pc_o !== 32'h4) begin fails++; $display("FAIL rmf_next got %h exp 00000004", ifa.pc_o); end
    endtask

    task automatic test_flush_one();
        do_reset();
        ifb.branch_i = 1; ifb.br_sig_i = 1; ifb.ex_pc_i = 32'h40; ifb.imm_i = 32'h10;
        #1;
        tests++; if (ifb.flush_o !== 1'b1) begin fails++; $display("FAIL f1_flush0 got %b exp 1", ifb.flush_o); end
        tick(); idle();
        // a jump in the very next cycle is only accepted if the unit stayed in RUN
        ifb.jal_i = 1; ifb.ex_pc_i = 32'hFFFF_FFFC; ifb.imm_i = 32'h8;
        #1;
        tests++; if (ifb.pc_o !== 32'h50) begin fails++; $display("FAIL f1_target got %h exp 00000050", ifb.pc_o); end
        tests++; if (ifb.redirect_o !== 1'b1) begin fails++; $display("FAIL f1_run_redirect got %b exp 1", ifb.redirect_o); end
        tick(); idle(); #1;
        tests++; if (ifb.pc_o !== 32'h4) begin fails++; $display("FAIL f1_wrap got %h exp 00000004", ifb.pc_o); end
        tests++; if (ifb.flush_o !== 1'b0) begin fails++; $display("FAIL f1_flush1 got %b exp 0", ifb.flush_o); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b0;
        idle();
        test_reset();
        test_branch();
        test_jalr_stall();
        test_jal_misalign();
        test_flush_stall();
        test_halt();
        test_reset_mid_flush();
        test_flush_one();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
